// File: rtl/simon_pkg.sv
// Shared SIMON 128/256 result-path definitions: block type, capture states, sizing helper.
package simon_pkg;
  localparam int SIMON_N       = 64;
  localparam int SIMON_BLOCK_W = 2 * SIMON_N;

  typedef logic [SIMON_BLOCK_W-1:0] simon_block_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_ACK  = 1'b1
  } cap_state_t;

  function automatic int words_per_block(input int n, input int w);
    return (2 * n) / w;
  endfunction
endpackage

// File: rtl/simon_cipher_drain_if.sv
// Core result handshake, outbound word stream and FIFO status bundled for simon_cipher_drain.
interface simon_cipher_drain_if #(
  parameter int N     = 64,
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  logic                         doneData;
  logic [2*N-1:0]               cipher;
  logic                         readData;
  logic                         out_valid;
  logic                         out_ready;
  logic [W-1:0]                 out_data;
  logic                         out_last;
  logic                         full;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    input  doneData, cipher, out_ready,
    output readData, out_valid, out_data, out_last, full, empty, count
  );

  modport slave (
    output doneData, cipher, out_ready,
    input  readData, out_valid, out_data, out_last, full, empty, count
  );
endinterface

// File: rtl/simon_block_fifo.sv
// Circular block buffer; head visible one cycle after push, count-derived full/empty.
// Push ignored while full, pop ignored while empty (the caller gates on the flags).
module simon_block_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr;
  logic             rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/simon_cipher_drain.sv
// Captures SIMON result blocks via doneData/readData and streams them out MSW-first as W-bit words.
// Block visible one cycle after capture; readData withheld while the FIFO is full, words held while out_ready=0.
module simon_cipher_drain
  import simon_pkg::*;
#(
  parameter int N     = SIMON_N,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nR,
  simon_cipher_drain_if.master bus
);
  localparam int BW  = 2 * N;
  localparam int WPB = words_per_block(N, W);
  localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  cap_state_t      state;
  cap_state_t      nxt;
  logic            push;
  logic            pop;
  logic            xfer;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [BW-1:0]   head;
  logic [BW-1:0]   shifted;
  logic [IW-1:0]   widx;

  simon_block_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nR    (nR),
    .push  (push),
    .pop   (pop),
    .din   (bus.cipher),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) state <= C_IDLE;
    else     state <= nxt;
  end

  // One write per doneData pulse: the write only happens on the IDLE->ACK transition.
  always_comb begin
    nxt  = state;
    push = 1'b0;
    case (state)
      C_IDLE: begin
        if (bus.doneData && !full) begin
          push = 1'b1;
          nxt  = C_ACK;
        end
      end
      C_ACK: begin
        if (!bus.doneData) nxt = C_IDLE;
      end
      default: nxt = C_IDLE;
    endcase
  end

  assign bus.readData  = (state == C_ACK);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.out_valid = !empty;

  assign shifted      = head << (int'(widx) * W);
  assign bus.out_data = shifted[BW-1 -: W];
  assign bus.out_last = !empty && (widx == IW'(WPB - 1));

  assign xfer = bus.out_valid && bus.out_ready;
  assign pop  = xfer && bus.out_last;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      widx <= '0;
    end else if (xfer) begin
      if (bus.out_last) widx <= '0;
      else              widx <= widx + IW'(1);
    end
  end
endmodule

// File: tb/tb_simon_cipher_drain.sv
// Randomised bench for simon_cipher_drain against an in-order block queue model.
module tb_simon_cipher_drain;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  simon_cipher_drain_if #(.N(64), .W(32), .DEPTH(4)) bus ();

  simon_cipher_drain #(.N(64), .W(32), .DEPTH(4)) dut (
    .clk (clk),
    .nR  (nR),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  simon_block_t model_q[$];
  int           model_widx = 0;
  logic         mon_on    = 1'b0;
  logic         rnd_en    = 1'b0;
  logic         ready_val = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic simon_block_t rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sole driver of out_ready.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Stream monitor: words must follow the model queue, MSW first, stable while stalled.
  initial begin
    logic        sv, sr, sl, stall, stall_l;
    logic [31:0] sd, stall_d, ew;
    simon_block_t e;
    stall = 1'b0; stall_d = '0; stall_l = 1'b0;
    forever begin
      @(negedge clk);
      sv = bus.out_valid; sr = bus.out_ready; sd = bus.out_data; sl = bus.out_last;
      if (mon_on && nR) begin
        check("count", bus.count, model_q.size());
        check("empty", bus.empty, model_q.size() == 0);
        check("full", bus.full, model_q.size() == 4);
        check("out_valid", sv, model_q.size() != 0);
        if (stall && sv) begin
          check("stall_data", sd, stall_d);
          check("stall_last", sl, stall_l);
        end
      end
      @(posedge clk);
      if (!nR) begin
        stall = 1'b0;
      end else if (mon_on) begin
        if (sv && sr) begin
          check("word_has_model", model_q.size() != 0, 1);
          if (model_q.size() != 0) begin
            e  = model_q[0];
            ew = 32'(e >> (32 * (3 - model_widx)));
            check("word", sd, ew);
            check("last", sl, model_widx == 3);
            if (model_widx == 3) begin
              model_widx = 0;
              void'(model_q.pop_front());
            end else begin
              model_widx++;
            end
          end
        end
        stall   = sv && !sr;
        stall_d = sd;
        stall_l = sl;
      end
    end
  end

  task automatic deliver(input simon_block_t blk, input int hold, output int lat);
    bus.doneData = 1'b1;
    bus.cipher   = blk;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.readData && lat < 200);
    check("ack_seen", bus.readData, 1);
    if (bus.readData) model_q.push_back(blk);
    for (int i = 1; i < hold; i++) begin
      tick();
      check("ack_hold", bus.readData, 1);
    end
    bus.doneData = 1'b0;
    tick();
    check("ack_fall", bus.readData, 0);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!bus.empty && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", bus.empty, 1);
  endtask

  initial begin
    int           lat;
    simon_block_t blks [5];
    simon_block_t c;
    logic         pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.doneData = 1'b0;
    bus.cipher   = '0;
    #1;
    check("rst_readData", bus.readData, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_out_last", bus.out_last, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nR = 1'b1;
    mon_on = 1'b1;

    // Single block with known words
    ready_val = 1'b1;
    deliver(128'h8D2B5579AFC8A3A03BF72A87EFE7B868, 3, lat);
    check("t1_ack_lat", lat, 1);
    wait_empty();

    // Long doneData: one write only
    ready_val = 1'b0;
    tick();
    deliver(rand_block(), 10, lat);
    check("t2_count", bus.count, 1);
    ready_val = 1'b1;
    wait_empty();

    // Fill, back-pressure the core, then release
    ready_val = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) blks[i] = rand_block();
    for (int i = 0; i < 4; i++) deliver(blks[i], 1, lat);
    check("t3_full", bus.full, 1);
    bus.doneData = 1'b1;
    bus.cipher   = blks[4];
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_ack", bus.readData, 0);
    end
    ready_val = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.readData && lat < 50);
    check("t3_ack_after_pop", lat, 5);
    if (bus.readData) model_q.push_back(blks[4]);
    bus.doneData = 1'b0;
    tick();
    wait_empty();

    // Stall mid-block
    ready_val = 1'b0;
    tick();
    deliver(rand_block(), 1, lat);
    foreach (pat[i]) begin
      ready_val = pat[i];
      tick();
    end
    wait_empty();

    // Capture on the same edge as a last-word pop
    ready_val = 1'b0;
    tick();
    deliver(rand_block(), 1, lat);
    deliver(rand_block(), 1, lat);
    check("t5_count_pre", bus.count, 2);
    ready_val = 1'b1;
    repeat (3) tick();
    c = rand_block();
    bus.doneData = 1'b1;
    bus.cipher   = c;
    tick();
    check("t5_ack", bus.readData, 1);
    if (bus.readData) model_q.push_back(c);
    check("t5_count", bus.count, 2);
    bus.doneData = 1'b0;
    tick();
    wait_empty();

    // Async reset while in C_ACK and mid-serialisation
    ready_val = 1'b0;
    tick();
    deliver(rand_block(), 1, lat);
    c = rand_block();
    bus.doneData = 1'b1;
    bus.cipher   = c;
    tick();
    check("t6_ack", bus.readData, 1);
    if (bus.readData) model_q.push_back(c);
    ready_val = 1'b1;
    repeat (2) tick();
    nR = 1'b0;
    #1;
    check("t6_rst_readData", bus.readData, 0);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_count", bus.count, 0);
    check("t6_rst_empty", bus.empty, 1);
    model_q.delete();
    model_widx   = 0;
    bus.doneData = 1'b0;
    ready_val    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nR = 1'b1;
    ready_val = 1'b1;
    deliver(rand_block(), 1, lat);
    check("t6_post_ack_lat", lat, 1);
    wait_empty();

    // Randomised traffic with random back-pressure
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      deliver(rand_block(), $urandom_range(1, 4), lat);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_en    = 1'b0;
    ready_val = 1'b1;
    tick();
    wait_empty();
    tick();
    check("final_model_empty", model_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
